ram_bank: RTL

- Parametrised single-clock, one-read-port plus one-write-port word memory with per-byte write strobes.
- Serves as the successor to the fixed 32-bit instruction/data store.
- Adds a registered read port with request/valid handshake, read-after-write bypass, range and alignment error reporting, and a sequential post-reset clear engine that replaces the single-cycle array reset.
- Sits between the core fetch/LSU bus adapters and the memory map.

---
 rtl/ram_bank.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ram_bank.sv
// ram_bank: single-clock word memory, one read port + one byte-strobed write port.
// Latency: read data and write ack/err appear one cycle after acceptance.
// Backpressure: both ports are stalled (ready low) while the post-reset clear runs.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   init_busy_o           clear engine running; neither port ready
//   r_req_i/r_ready_o     read request / read accepted this cycle
//   r_addr_i              read byte address
//   r_valid_o/r_data_o    read response pulse and data (data held between pulses)
//   r_err_o               response was out of range or misaligned
//   w_en_i/w_ready_o      write request / write accepted this cycle
//   w_addr_i/w_data_i     write byte address and data
//   w_sel_i               byte-lane strobes
//   w_ack_o/w_err_o       write completed / write rejected, one-cycle pulses
module ram_bank #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 16384,
  parameter int DEPTH_BITS  = 14,
  parameter int OFFSET_BITS = 2,
  parameter int INIT_CLEAR  = 1,
  parameter int BYPASS      = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    init_busy_o,
  input  logic                    r_req_i,
  output logic                    r_ready_o,
  input  logic [ADDR_WIDTH-1:0]   r_addr_i,
  output logic                    r_valid_o,
  output logic [DATA_WIDTH-1:0]   r_data_o,
  output logic                    r_err_o,
  input  logic                    w_en_i,
  output logic                    w_ready_o,
  input  logic [ADDR_WIDTH-1:0]   w_addr_i,
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  input  logic [DATA_WIDTH/8-1:0] w_sel_i,
  output logic                    w_ack_o,
  output logic                    w_err_o
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int IDX_HI = OFFSET_BITS + DEPTH_BITS;

  typedef logic [DEPTH_BITS-1:0] idx_t;

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((1 << OFFSET_BITS) - 1);
  localparam logic [DEPTH_BITS:0]   DEPTH_LIM = (DEPTH_BITS + 1)'(DEPTH);
  localparam idx_t                  LAST_IDX  = DEPTH_BITS'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;
  localparam state_t RST_STATE = (INIT_CLEAR != 0) ? S_CLEAR : S_RUN;

  state_t                state_q;
  idx_t                  clr_cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  r_valid_q, r_err_q, w_ack_q, w_err_q;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic                  r_valid_d, r_err_d;
  logic [DATA_WIDTH-1:0] r_data_d, r_word, r_merged;

  idx_t r_idx, w_idx;
  logic r_in, w_in, r_acc, w_acc, byp_hit, busy;

  // Aligned, index below DEPTH, and nothing set above the index field.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [DEPTH_BITS-1:0] i;
    i = a[IDX_HI-1:OFFSET_BITS];
    return ((a & OFF_MASK) == '0) && ({1'b0, i} < DEPTH_LIM) && ((a >> IDX_HI) == '0);
  endfunction

  assign r_idx = r_addr_i[IDX_HI-1:OFFSET_BITS];
  assign w_idx = w_addr_i[IDX_HI-1:OFFSET_BITS];
  assign r_in  = in_range(r_addr_i);
  assign w_in  = in_range(w_addr_i);

  assign busy        = (state_q == S_CLEAR);
  assign init_busy_o = busy;
  assign r_ready_o   = ~busy;
  assign w_ready_o   = ~busy;
  assign r_acc       = r_req_i & ~busy;
  assign w_acc       = w_en_i & ~busy;

  // Clear engine: one word per cycle from index 0, then run forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + idx_t'(1);
          if (clr_cnt_q == LAST_IDX) state_q <= S_RUN;
        end
        S_RUN:   state_q <= S_RUN;
        default: state_q <= S_RUN;
      endcase
    end
  end

  // Array has no reset; writes are suppressed while rst_n is held low so
  // reset alone never disturbs the contents.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (busy) begin
        mem_q[clr_cnt_q] <= '0;
      end else if (w_acc && w_in) begin
        for (int k = 0; k < NB; k++) begin
          if (w_sel_i[k]) mem_q[w_idx][8*k +: 8] <= w_data_i[8*k +: 8];
        end
      end
    end
  end

  // Same-cycle read/write to one index: optionally forward the strobed merge.
  always_comb begin
    r_word   = r_in ? mem_q[r_idx] : '0;
    r_merged = r_word;
    for (int k = 0; k < NB; k++) begin
      if (w_sel_i[k]) r_merged[8*k +: 8] = w_data_i[8*k +: 8];
    end
    byp_hit   = (BYPASS != 0) && w_acc && w_in && (w_idx == r_idx);
    r_valid_d = r_acc;
    r_err_d   = r_err_q;
    r_data_d  = r_data_q;
    if (r_acc) begin
      r_err_d  = ~r_in;
      r_data_d = !r_in ? '0 : (byp_hit ? r_merged : r_word);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_q <= 1'b0;
      r_err_q   <= 1'b0;
      r_data_q  <= '0;
      w_ack_q   <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      r_valid_q <= r_valid_d;
      r_err_q   <= r_err_d;
      r_data_q  <= r_data_d;
      w_ack_q   <= w_acc & w_in;
      w_err_q   <= w_acc & ~w_in;
    end
  end

  assign r_valid_o = r_valid_q;
  assign r_err_o   = r_err_q;
  assign r_data_o  = r_data_q;
  assign w_ack_o   = w_ack_q;
  assign w_err_o   = w_err_q;

endmodule
